// File: rtl/alu_seq.sv
// alu_seq: handshaked 6502-style arithmetic unit with N/V/Z/C generation
// and an optional per-digit BCD correction step for ADC/SBC.
// Handshake: start is sampled only in IDLE. busy is high in EXEC/ADJ.
// done pulses for one cycle in DONE. result/status_out/result_we/illegal
// are valid while done is high and are held until the next accepted start.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter bit DEC_EN = 1'b1
) (
    input  logic             phi1,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       status_in,
    input  logic             dec_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       status_out,
    output logic             result_we,
    output logic             illegal,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ADJ, S_DONE} state_e;

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    localparam logic [3:0] OP_ADC = 4'h0, OP_SBC = 4'h1, OP_AND = 4'h2,
                           OP_ORA = 4'h3, OP_EOR = 4'h4, OP_ASL = 4'h5,
                           OP_LSR = 4'h6, OP_ROL = 4'h7, OP_ROR = 4'h8,
                           OP_INC = 4'h9, OP_DEC = 4'hA, OP_CMP = 4'hB,
                           OP_BIT = 4'hC;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [7:0]       p_q, p_d;
    logic             dec_q, dec_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [7:0]       status_q, status_d;
    logic             result_we_q, result_we_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] bin_res;
    logic [7:0]       bin_p;
    logic             bin_we, bin_ill, nz_upd;
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   sum, diff, dec_sum;

    // Decimal add/subtract digit by digit; returns {carry, result}.
    // For subtraction the carry is "no borrow", matching the 6502 C flag.
    function automatic logic [WIDTH:0] bcd_calc(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic cin,
                                                 input logic sub);
        logic [WIDTH-1:0] r;
        logic             c;
        logic [4:0]       s;
        logic [3:0]       yd;
        r = '0;
        c = cin;
        for (int i = 0; i < WIDTH / 4; i++) begin
            yd = sub ? ~y[4*i +: 4] : y[4*i +: 4];
            s  = {1'b0, x[4*i +: 4]} + {1'b0, yd} + {4'b0, c};
            if (sub) begin
                c = s[4];
                r[4*i +: 4] = c ? s[3:0] : s[3:0] - 4'd6;
            end else begin
                if (s > 5'd9) s = s + 5'd6;
                c = s[4];
                r[4*i +: 4] = s[3:0];
            end
        end
        return {c, r};
    endfunction

    // Binary datapath: result and flags for the latched operation.
    always_comb begin
        bp      = (op_q == OP_SBC) ? ~b_q : b_q;
        sum     = {1'b0, a_q} + {1'b0, bp} + {{WIDTH{1'b0}}, p_q[0]};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        dec_sum = bcd_calc(a_q, b_q, p_q[0], op_q == OP_SBC);
        bin_res = '0;
        bin_p   = p_q | 8'h20;
        bin_we  = 1'b1;
        bin_ill = 1'b0;
        nz_upd  = 1'b1;
        case (op_q)
            OP_ADC, OP_SBC: begin
                bin_res  = sum[MSB:0];
                bin_p[0] = sum[WIDTH];
                bin_p[6] = (a_q[MSB] == bp[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_AND: bin_res = a_q & b_q;
            OP_ORA: bin_res = a_q | b_q;
            OP_EOR: bin_res = a_q ^ b_q;
            OP_ASL: begin bin_res = {a_q[MSB-1:0], 1'b0};    bin_p[0] = a_q[MSB]; end
            OP_ROL: begin bin_res = {a_q[MSB-1:0], p_q[0]};  bin_p[0] = a_q[MSB]; end
            OP_LSR: begin bin_res = {1'b0, a_q[MSB:1]};      bin_p[0] = a_q[0];   end
            OP_ROR: begin bin_res = {p_q[0], a_q[MSB:1]};    bin_p[0] = a_q[0];   end
            OP_INC: bin_res = a_q + ONE;
            OP_DEC: bin_res = a_q - ONE;
            OP_CMP: begin
                bin_res  = a_q;
                nz_upd   = 1'b0;
                bin_we   = 1'b0;
                bin_p[0] = ~diff[WIDTH];
                bin_p[1] = (a_q == b_q);
                bin_p[7] = diff[MSB];
            end
            OP_BIT: begin
                bin_res  = a_q;
                nz_upd   = 1'b0;
                bin_we   = 1'b0;
                bin_p[1] = ((a_q & b_q) == '0);
                bin_p[7] = b_q[MSB];
                bin_p[6] = b_q[MSB-1];
            end
            default: begin
                nz_upd  = 1'b0;
                bin_we  = 1'b0;
                bin_ill = 1'b1;
            end
        endcase
        if (nz_upd) begin
            bin_p[7] = bin_res[MSB];
            bin_p[1] = (bin_res == '0);
        end
    end

    // Sequencer: operand capture, binary execute, optional BCD adjust, done.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        dec_d       = dec_q;
        result_d    = result_q;
        status_d    = status_q;
        result_we_d = result_we_q;
        illegal_d   = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    p_d     = status_in;
                    dec_d   = dec_mode;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d    = bin_res;
                status_d    = bin_p;
                result_we_d = bin_we;
                illegal_d   = bin_ill;
                if (DEC_EN && dec_q && (op_q == OP_ADC || op_q == OP_SBC))
                    state_d = S_ADJ;
                else
                    state_d = S_DONE;
            end
            S_ADJ: begin
                // V stays from the binary intermediate; C/Z/N follow the digits.
                result_d    = dec_sum[MSB:0];
                status_d[0] = dec_sum[WIDTH];
                status_d[1] = (dec_sum[MSB:0] == '0);
                status_d[7] = dec_sum[MSB];
                state_d     = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge phi1) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 4'h0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= 8'h00;
            dec_q       <= 1'b0;
            result_q    <= '0;
            status_q    <= 8'h20;
            result_we_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            dec_q       <= dec_d;
            result_q    <= result_d;
            status_q    <= status_d;
            result_we_q <= result_we_d;
            illegal_q   <= illegal_d;
        end
    end

    assign busy       = (state_q == S_EXEC) || (state_q == S_ADJ);
    assign done       = (state_q == S_DONE);
    assign result     = result_q;
    assign status_out = status_q;
    assign result_we  = result_we_q;
    assign illegal    = illegal_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: one task per scenario, inline checks.
module tb_alu_seq;

  logic       phi1 = 1'b0;
  logic       reset, start, dec_mode;
  logic [3:0] op;
  logic [7:0] a, b, status_in;
  logic       busy, done, result_we, illegal;
  logic [7:0] result, status_out;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(8), .DEC_EN(1'b1)) dut (
    .phi1(phi1), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .status_in(status_in), .dec_mode(dec_mode), .busy(busy), .done(done),
    .result(result), .status_out(status_out), .result_we(result_we),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  // clock
  always #5 phi1 = ~phi1;

  // Drive one op with a single-cycle start, wait (bounded) for done.
  // Called and returns at #1 after a rising edge; lat counts edges to done.
  task automatic run_op(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                        input logic [7:0] p, input logic d, output int lat);
    op = o; a = xa; b = xb; status_in = p; dec_mode = d; start = 1'b1;
    lat = 0;
    do begin
      @(posedge phi1); #1;
      start = 1'b0;
      lat++;
    end while (!done && lat < 20);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 4'h0; a = 8'h00; b = 8'h00; status_in = 8'h00; dec_mode = 1'b0;
    repeat (2) begin @(posedge phi1); #1; end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (result !== 8'h00)     begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
    total++; if (status_out !== 8'h20) begin bad++; $display("FAIL reset_status got=%h exp=20", status_out); end
    total++; if (result_we !== 1'b0 || illegal !== 1'b0)
      begin bad++; $display("FAIL reset_we_ill got=%b%b exp=00", result_we, illegal); end
    reset = 1'b0;
  endtask

  task automatic test_adc;
    int lat;
    run_op(4'h0, 8'h50, 8'h50, 8'h00, 1'b0, lat);
    total++; if (lat !== 2)            begin bad++; $display("FAIL adc_bin_lat got=%0d exp=2", lat); end
    total++; if (result !== 8'hA0)     begin bad++; $display("FAIL adc_bin_res got=%h exp=a0", result); end
    total++; if (status_out !== 8'hE0) begin bad++; $display("FAIL adc_bin_p got=%h exp=e0", status_out); end
    total++; if (result_we !== 1'b1 || illegal !== 1'b0)
      begin bad++; $display("FAIL adc_bin_we got=%b%b exp=10", result_we, illegal); end
    @(posedge phi1); #1;
    run_op(4'h0, 8'h19, 8'h28, 8'h08, 1'b1, lat);
    total++; if (lat !== 3)            begin bad++; $display("FAIL adc_dec_lat got=%0d exp=3", lat); end
    total++; if (result !== 8'h47)     begin bad++; $display("FAIL adc_dec_res got=%h exp=47", result); end
    total++; if (status_out !== 8'h28) begin bad++; $display("FAIL adc_dec_p got=%h exp=28", status_out); end
    @(posedge phi1); #1;
    run_op(4'h0, 8'h99, 8'h01, 8'h08, 1'b1, lat);
    total++; if (result !== 8'h00)     begin bad++; $display("FAIL adc_wrap_res got=%h exp=00", result); end
    total++; if (status_out !== 8'h2B) begin bad++; $display("FAIL adc_wrap_p got=%h exp=2b", status_out); end
    @(posedge phi1); #1;
  endtask

  task automatic test_sbc;
    int lat;
    run_op(4'h1, 8'h00, 8'h01, 8'h01, 1'b0, lat);
    total++; if (lat !== 2)            begin bad++; $display("FAIL sbc_bin_lat got=%0d exp=2", lat); end
    total++; if (result !== 8'hFF)     begin bad++; $display("FAIL sbc_bin_res got=%h exp=ff", result); end
    total++; if (status_out !== 8'hA0) begin bad++; $display("FAIL sbc_bin_p got=%h exp=a0", status_out); end
    @(posedge phi1); #1;
    run_op(4'h1, 8'h00, 8'h01, 8'h09, 1'b1, lat);
    total++; if (lat !== 3)            begin bad++; $display("FAIL sbc_dec_lat got=%0d exp=3", lat); end
    total++; if (result !== 8'h99)     begin bad++; $display("FAIL sbc_dec_res got=%h exp=99", result); end
    total++; if (status_out !== 8'hA8) begin bad++; $display("FAIL sbc_dec_p got=%h exp=a8", status_out); end
    @(posedge phi1); #1;
  endtask

  task automatic test_logic_shift_cmp;
    int lat;
    run_op(4'h8, 8'h01, 8'h00, 8'h01, 1'b0, lat);
    total++; if (result !== 8'h80)     begin bad++; $display("FAIL ror_res got=%h exp=80", result); end
    total++; if (status_out !== 8'hA1) begin bad++; $display("FAIL ror_p got=%h exp=a1", status_out); end
    @(posedge phi1); #1;
    run_op(4'h2, 8'hF0, 8'h0F, 8'hC3, 1'b1, lat);
    total++; if (lat !== 2)            begin bad++; $display("FAIL and_lat got=%0d exp=2", lat); end
    total++; if (result !== 8'h00)     begin bad++; $display("FAIL and_res got=%h exp=00", result); end
    total++; if (status_out !== 8'h63) begin bad++; $display("FAIL and_p got=%h exp=63", status_out); end
    @(posedge phi1); #1;
    run_op(4'hB, 8'h40, 8'h40, 8'h00, 1'b0, lat);
    total++; if (result !== 8'h40)     begin bad++; $display("FAIL cmp_res got=%h exp=40", result); end
    total++; if (status_out !== 8'h23) begin bad++; $display("FAIL cmp_p got=%h exp=23", status_out); end
    total++; if (result_we !== 1'b0)   begin bad++; $display("FAIL cmp_we got=%b exp=0", result_we); end
    @(posedge phi1); #1;
    run_op(4'hC, 8'h0F, 8'hC0, 8'h00, 1'b0, lat);
    total++; if (status_out !== 8'hE2) begin bad++; $display("FAIL bit_p got=%h exp=e2", status_out); end
    total++; if (result !== 8'h0F || result_we !== 1'b0)
      begin bad++; $display("FAIL bit_res got=%h/%b exp=0f/0", result, result_we); end
    @(posedge phi1); #1;
  endtask

  task automatic test_illegal;
    int lat;
    run_op(4'hE, 8'h55, 8'h33, 8'hC3, 1'b0, lat);
    total++; if (lat !== 2)            begin bad++; $display("FAIL ill_lat got=%0d exp=2", lat); end
    total++; if (illegal !== 1'b1)     begin bad++; $display("FAIL ill_flag got=%b exp=1", illegal); end
    total++; if (status_out !== 8'hE3) begin bad++; $display("FAIL ill_p got=%h exp=e3", status_out); end
    total++; if (result !== 8'h00 || result_we !== 1'b0)
      begin bad++; $display("FAIL ill_res got=%h/%b exp=00/0", result, result_we); end
    @(posedge phi1); #1;
  endtask

  // start held high through EXEC/ADJ/DONE of a decimal op: one done only.
  task automatic test_start_ignored;
    int n_done = 0;
    int at = -1;
    op = 4'h0; a = 8'h19; b = 8'h28; status_in = 8'h00; dec_mode = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge phi1); #1;
      if (i == 2) start = 1'b0;
      if (done) begin n_done++; at = i; end
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL ign_count got=%0d exp=1", n_done); end
    total++; if (at !== 2)     begin bad++; $display("FAIL ign_when got=%0d exp=2", at); end
  endtask

  // start held high continuously: accepts every 3 cycles.
  task automatic test_back_to_back;
    int n_done = 0;
    int first = -1;
    int second = -1;
    op = 4'h9; a = 8'h7F; b = 8'h00; status_in = 8'h00; dec_mode = 1'b0; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge phi1); #1;
      if (i == 0) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
      end
      if (i == 5) start = 1'b0;
      if (done) begin
        n_done++;
        if (first < 0) first = i; else second = i;
        total++; if (result !== 8'h80 || status_out !== 8'hA0)
          begin bad++; $display("FAIL b2b_res got=%h/%h exp=80/a0", result, status_out); end
      end
    end
    total++; if (n_done !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", n_done); end
    total++; if (first !== 1 || second !== 4)
      begin bad++; $display("FAIL b2b_when got=%0d,%0d exp=1,4", first, second); end
  endtask

  // reset while in ADJ abandons the op.
  task automatic test_reset_mid;
    int n_done = 0;
    op = 4'h0; a = 8'h19; b = 8'h28; status_in = 8'h00; dec_mode = 1'b1; start = 1'b1;
    @(posedge phi1); #1; start = 1'b0;
    @(posedge phi1); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_adj got=%b exp=1", busy); end
    reset = 1'b1;
    @(posedge phi1); #1;
    reset = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL rmid_hs got=%b%b exp=00", busy, done); end
    total++; if (result !== 8'h00)     begin bad++; $display("FAIL rmid_res got=%h exp=00", result); end
    total++; if (status_out !== 8'h20) begin bad++; $display("FAIL rmid_p got=%h exp=20", status_out); end
    for (int i = 0; i < 4; i++) begin
      @(posedge phi1); #1;
      if (done) n_done++;
    end
    total++; if (n_done !== 0) begin bad++; $display("FAIL rmid_nodone got=%0d exp=0", n_done); end
  endtask

  initial begin
    test_reset;
    test_adc;
    test_sbc;
    test_logic_shift_cmp;
    test_illegal;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
